// File: rtl/shift_multiplier.sv
// Sequential unsigned shift-and-add multiplier with valid/ready on both sides.
// One multiplier bit is consumed per clock; the product is double width and
// appears a fixed 2**DW cycles after the operands are accepted.
module shift_multiplier #(
  parameter int unsigned DW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2**DW-1:0]      A,
  input  logic [2**DW-1:0]      B,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [2*(2**DW)-1:0]  P,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned W = 2 ** DW;
  localparam logic [DW-1:0] LastCount = DW'(W - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [2*W-1:0]  mcand_q;
  logic [2*W-1:0]  acc_q;
  logic [W-1:0]    mplier_q;
  logic [DW-1:0]   count_q;
  logic            in_ready_q;
  logic            out_valid_q;

  // Control FSM and datapath; handshake outputs are registered alongside state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            mcand_q    <= {{W{1'b0}}, A};
            mplier_q   <= B;
            acc_q      <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 1'b1;
          // count_q is the index of the iteration happening on this edge.
          if (count_q == LastCount) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The accumulator is frozen outside RUN, so it can drive P directly.
  assign P         = acc_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shift_multiplier.sv
// Directed bench for shift_multiplier (DW=4): latency, boundary values,
// divider round-trip, backpressure, mid-run reset and back-to-back traffic.
module tb_shift_multiplier;

  localparam int unsigned DW = 4;
  localparam int unsigned W  = 2 ** DW;

  logic             clk;
  logic             rst;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic             in_valid;
  logic             in_ready;
  logic [2*W-1:0]   P;
  logic             out_valid;
  logic             out_ready;

  int n_cmp;
  int n_bad;

  shift_multiplier #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .P         (P),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid after a capture edge; reports latency and
  // whether in_ready was ever seen high while busy.
  task automatic wait_done(output int lat, output bit ready_seen);
    lat = 0;
    ready_seen = in_ready;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
      if (in_ready) ready_seen = 1'b1;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, output logic [2*W-1:0] p_got);
    int lat;
    bit rs;
    A = a;
    B = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = ~a;
    B = ~b;
    wait_done(lat, rs);
    chk({tag, "_latency"}, 64'(lat), 64'(W));
    chk({tag, "_busy_ready"}, 64'(rs), 64'd0);
    chk({tag, "_P"}, 64'(P), 64'(exp));
    p_got = P;
    tick();
    chk({tag, "_retired_ov"}, 64'(out_valid), 64'd0);
    chk({tag, "_retired_ir"}, 64'(in_ready), 64'd1);
  endtask

  logic [W-1:0]   va [50];
  logic [W-1:0]   vb [50];

  initial begin
    logic [2*W-1:0] pg;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    int lat;
    bit rs;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    A = '0;
    B = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    chk("reset_ir", 64'(in_ready), 64'd1);
    chk("reset_ov", 64'(out_valid), 64'd0);
    chk("reset_P", 64'(P), 64'd0);

    // Basic operation and boundary operands
    run_op("t1_3x5", 16'd3, 16'd5, 32'h0000_000F, pg);
    run_op("t2_max", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, pg);
    run_op("t2_zero", 16'h1234, 16'h0000, 32'h0, pg);
    run_op("t2_zeroA", 16'h0000, 16'hABCD, 32'h0, pg);

    // Divider round-trip: Q*2^S + R must rebuild I
    for (int s = 0; s < 16; s++) begin
      q = 16'hBEEF >> s;
      r = 16'hBEEF & 16'((32'd1 << s) - 1);
      run_op($sformatf("t3_s%0d", s), q, 16'(32'd1 << s), 32'(q) << s, pg);
      chk($sformatf("t3_round_s%0d", s), 64'(pg + 32'(r)), 64'h0000_BEEF);
    end

    // Backpressure: hold DONE, inputs wiggle and must be ignored
    out_ready = 1'b0;
    A = 16'h0101;
    B = 16'h0202;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(lat, rs);
    chk("t4_latency", 64'(lat), 64'(W));
    for (int i = 0; i < 10; i++) begin
      A = 16'($urandom);
      B = 16'($urandom);
      in_valid = 1'(i % 2);
      tick();
      chk($sformatf("t4_hold_P%0d", i), 64'(P), 64'h0002_0402);
      chk($sformatf("t4_hold_ov%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("t4_hold_ir%0d", i), 64'(in_ready), 64'd0);
    end
    // in_valid and out_ready together in DONE: only the retire happens
    A = 16'd2;
    B = 16'd3;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("t4_retire_ov", 64'(out_valid), 64'd0);
    chk("t4_retire_ir", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("t4_accept_ir", 64'(in_ready), 64'd0);
    wait_done(lat, rs);
    chk("t4_next_latency", 64'(lat), 64'(W));
    chk("t4_next_P", 64'(P), 64'd6);
    tick();

    // Reset in the middle of a run
    A = 16'h00FF;
    B = 16'h0F0F;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("t5_busy_ov", 64'(out_valid), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_ir", 64'(in_ready), 64'd1);
    chk("t5_rst_ov", 64'(out_valid), 64'd0);
    chk("t5_rst_P", 64'(P), 64'd0);
    run_op("t5_7x9", 16'd7, 16'd9, 32'd63, pg);

    // Back-to-back random pairs with in_valid held high
    va[0] = 16'hFFFF;
    vb[0] = 16'hFFFF;
    va[1] = 16'h0000;
    vb[1] = 16'h8001;
    for (int i = 2; i < 50; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
    end
    begin
      int n_acc;
      int n_out;
      int last_acc;
      bit acc;
      n_acc = 0;
      n_out = 0;
      last_acc = 0;
      A = va[0];
      B = vb[0];
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 50 * 18 + 100 && n_out < 50; cyc++) begin
        acc = in_ready && in_valid;
        tick();
        if (acc) begin
          if (n_acc > 0) chk($sformatf("t6_space%0d", n_acc), 64'(cyc - last_acc), 64'd18);
          last_acc = cyc;
          n_acc++;
          if (n_acc < 50) begin
            A = va[n_acc];
            B = vb[n_acc];
          end else begin
            in_valid = 1'b0;
          end
        end
        if (out_valid) begin
          chk($sformatf("t6_P%0d", n_out), 64'(P), 64'(32'(va[n_out]) * 32'(vb[n_out])));
          n_out++;
        end
      end
      chk("t6_outputs", 64'(n_out), 64'd50);
      chk("t6_accepts", 64'(n_acc), 64'd50);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_multiplier.md
Name: shift_multiplier

Overview:
- Sequential unsigned shift-and-add multiplier. It is the inverse-direction companion to the shift divider: it multiplies instead of dividing.
- Consumes one bit of the multiplier per clock and produces a double-width product.
- Used where a multiply is needed and area matters more than latency, e.g. scaling quotients back up, or rebuilding I = Q*2^S + R together with the divider's remainder.
- Valid/ready handshake on both input and output, so it can sit between registered datapath stages.

Parameters:
DW, 4, log2 of operand width; operands are 2**DW bits wide and the product is 2*2**DW bits wide.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
A  input  2**DW  multiplicand (unsigned)
B  input  2**DW  multiplier (unsigned)
in_valid  input  1  A/B valid
in_ready  output  1  block can accept operands
P  output  2*2**DW  product A*B (unsigned)
out_valid  output  1  P valid
out_ready  input  1  consumer accepts P

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is synchronous and active-high, sampled on the rising edge of clk. It overrides all other inputs.
- Reset values: state=IDLE, in_ready=1, out_valid=0, P=0, accumulator=0, count=0, operand registers=0.
- State machine: IDLE, RUN, DONE.
  - IDLE: in_ready=1, out_valid=0. If in_valid on an edge: capture A into the multiplicand register, zero-extended to 2*2**DW bits. Capture B into the multiplier register. Clear accumulator and count. Go to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge:
    - if multiplier register bit 0 = 1, accumulator += multiplicand register;
    - multiplicand register <<= 1; multiplier register >>= 1; count += 1.
    - When count reaches 2**DW-1 on this edge (the final iteration), go to DONE.
  - DONE: in_ready=0, out_valid=1, P=accumulator, held stable. On an edge with out_ready=1, go to IDLE and drop out_valid.
- Iteration count and latency:
  - Exactly 2**DW iterations regardless of operand values; no early exit. Latency is deterministic.
  - Operands are accepted on edge t. out_valid is first high in the cycle after edge t+2**DW, i.e. for DW=4 it rises after the 16th RUN edge.
  - Minimum spacing between accepted operand pairs is 2**DW+2 cycles when out_ready is held high.
- Arithmetic:
  - Unsigned only.
  - Accumulator and shifted multiplicand are 2*2**DW bits. The maximum product (2**(2**DW)-1)^2 fits without overflow, so no carry is lost.
  - P is registered and must not glitch while out_valid=1.
- Boundary conditions:
  - in_valid while in RUN or DONE: ignored. in_ready=0 signals this; no operands are captured or queued.
  - A or B = 0: still takes full latency; P=0.
  - out_ready held low: stays in DONE indefinitely; P and out_valid are held.
  - out_ready high when not in DONE: no effect.
  - in_valid and out_ready both high while in DONE: only the output is retired on that edge. New operands are accepted no earlier than the following edge, in IDLE.
  - rst asserted in RUN or DONE: the next edge returns the block to reset values and discards any pending result. out_valid is low the cycle after.
  - Operand inputs may change freely after capture; the result depends only on captured values.

Test Plan:
1. Reset, then A=3, B=5, in_valid for 1 cycle, out_ready=1 -> out_valid rises exactly 16 edges after capture, P=0x0000000F; in_ready=0 throughout RUN/DONE; back to IDLE one cycle later.
2. A=0xFFFF, B=0xFFFF -> P=0xFFFE0001. A=0x1234, B=0 -> P=0 with identical 16-cycle latency.
3. Divider round-trip: for I=0xBEEF and S=0..15, take Q=I>>S and R=I mod 2^S. Feed A=Q, B=2^S, then add R -> result equals 0x0000BEEF for every S.
4. Backpressure: out_ready=0 for 10 cycles after out_valid rises -> P constant, out_valid stays 1. Toggle new A/B/in_valid during this window -> ignored. Raise out_ready -> one transfer, then IDLE.
5. Reset mid-operation: assert rst at iteration 7 of A=0x00FF, B=0x0F0F -> next cycle in_ready=1, out_valid=0, P=0. A fresh A=7, B=9 then yields P=63 at normal latency.
6. Back-to-back: in_valid held high with a new pair presented on each acceptance, out_ready=1, 50 random pairs -> every P matches A*B; acceptances spaced exactly 18 cycles apart.
